// File: rtl/uart_byte_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular write FIFO.
// Bytes are serialised LSB first, back-to-back with one idle clock between frames.
module uart_byte_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic               uart_txd,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [DEPTH];

  logic empty;
  logic push;
  logic pop;
  logic baud_end;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_AW{1'b0}}});
  assign level    = wr_ptr_q - rd_ptr_q;
  assign push     = wr_en & ~full;
  assign baud_end = (baud_cnt_q == BAUD_LAST);

  assign overflow = ovf_q;
  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
          state_d    = START;
          txd_d      = 1'b0;
          baud_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
          txd_d      = shift_q[0];
        end
      end
      DATA: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        txd_d      = 1'b1;
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    // A write into a full FIFO is dropped even if a pop frees a slot this cycle
    ovf_d    = wr_en & full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_uart_byte_tx_fifo.sv
// Bench for uart_byte_tx_fifo: frame-level reference model plus
// serial decoder scoreboard checking every transmitted byte.
module tb_uart_byte_tx_fifo;

  localparam int D     = 10;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic [AW:0] level;
  logic        overflow;
  logic        uart_txd;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  uart_byte_tx_fifo #(
    .CLK_FREQ(1000),
    .BAUD    (100),
    .FIFO_AW (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .level   (level),
    .overflow(overflow),
    .uart_txd(uart_txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of waiting bytes and a frame timer
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur = 8'h00;
  int   tmr = 0;
  int   pre_size;
  bit   pre_idle;
  logic e_txd = 1'b1;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;
  logic e_ovf = 1'b0;
  int   e_level = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      exp_q.delete();
      tmr     = 0;
      e_txd   = 1'b1;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_ovf   = 1'b0;
      e_level = 0;
    end else begin
      pre_size = q.size();
      pre_idle = (tmr == 0);
      e_done   = 1'b0;
      if (tmr > 0) begin
        tmr--;
        if (tmr == 0) e_done = 1'b1;
      end
      e_ovf = wr_en && (pre_size == DEPTH);
      if (pre_idle && pre_size > 0) begin
        cur = q.pop_front();
        exp_q.push_back(cur);
        tmr = 10 * D;
      end
      if (wr_en && pre_size < DEPTH) q.push_back(wr_data);
      e_busy  = (tmr > 0);
      e_txd   = (tmr > 0) ? frame_bit(cur, (10 * D - tmr) / D) : 1'b1;
      e_level = q.size();
    end
  end

  always @(negedge clk) begin
    chk("txd", int'(uart_txd), int'(e_txd));
    chk("busy", int'(tx_busy), int'(e_busy));
    chk("done", int'(tx_done), int'(e_done));
    chk("ovf", int'(overflow), int'(e_ovf));
    chk("level", int'(level), e_level);
    chk("full", int'(full), int'(e_level == DEPTH));
  end

  // Serial decoder: reassembles bytes from uart_txd and pops the scoreboard
  bit         active = 1'b0;
  int         dcnt = 0;
  int         frames = 0;
  logic [7:0] dbyte = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      active = 1'b0;
    end else begin
      if (active) begin
        dcnt++;
        if ((dcnt % D) == D / 2 && dcnt < 10 * D) begin
          if (dcnt / D == 0)
            chk("start_bit", int'(uart_txd), 0);
          else if (dcnt / D <= 8)
            dbyte[dcnt/D-1] = uart_txd;
          else
            chk("stop_bit", int'(uart_txd), 1);
        end
      end else if (uart_txd == 1'b0) begin
        active = 1'b1;
        dcnt   = 0;
      end
      if (tx_done) begin
        if (!active) begin
          chk("done_without_frame", 1, 0);
        end else begin
          chk("frame_len", dcnt, 10 * D);
          if (exp_q.size() == 0)
            chk("unexpected_frame", int'(dbyte), -1);
          else
            chk("byte", int'(dbyte), int'(exp_q.pop_front()));
          frames++;
          active = 1'b0;
        end
      end
    end
  end

  task automatic put(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tmr == 0 && q.size() == 0 && !active) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_level", int'(level), 0);
    reset = 1'b1;
    @(negedge clk);

    put(8'hA5);
    wait_idle();

    put(8'h55);
    put(8'h0F);
    wait_idle();

    for (int i = 1; i <= 6; i++) put(8'(i));
    wait_idle();

    put(8'hC3);
    repeat (46) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_txd", int'(uart_txd), 1);
    chk("async_busy", int'(tx_busy), 0);
    chk("async_level", int'(level), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    put(8'h3C);
    wait_idle();

    put(8'h00);
    put(8'hFF);
    wait_idle();

    wr_en   = 1'b1;
    wr_data = 8'h77;
    repeat (30) @(negedge clk);
    wr_en = 1'b0;
    put(8'h11);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 99) < 4);
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) put(8'($urandom));
    wait_idle();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("frames_seen", int'(frames >= 20), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
